// File: rtl/param_seq_detector.sv
// param_seq_detector: serial pattern matcher with runtime-loadable
// pattern, overlap/non-overlap mode and a saturating match counter.
//   slowed_clk  : block clock, rising edge
//   reset       : synchronous, active-high
//   d_in/d_valid: serial bit, accepted when d_valid=1
//   pat_in/pat_load: runtime pattern load (clears history)
//   cnt_clr     : clears match_count
//   detected    : registered match flag, 1 cycle after match bit
//   match_count : saturating match count
module param_seq_detector #(
  parameter int                 PAT_LEN = 5,
  parameter logic [PAT_LEN-1:0] PATTERN = 5'b10001,
  parameter bit                 OVERLAP = 1'b1,
  parameter int                 CNT_W   = 8
) (
  input  logic               slowed_clk,
  input  logic               reset,
  input  logic               d_in,
  input  logic               d_valid,
  input  logic [PAT_LEN-1:0] pat_in,
  input  logic               pat_load,
  input  logic               cnt_clr,
  output logic               detected,
  output logic [CNT_W-1:0]   match_count
);

  localparam int FW = $clog2(PAT_LEN + 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PAT_LEN-1:0] pat_q, pat_d;
  logic [PAT_LEN-1:0] hist_q, hist_d;
  logic [FW-1:0]      fill_q, fill_d;
  logic               det_q, det_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [PAT_LEN-1:0] hist_sh;
  logic [FW-1:0]      fill_inc;
  logic               accept;
  logic               match;

  assign hist_sh  = {hist_q[PAT_LEN-2:0], d_in};
  assign fill_inc = (fill_q == FULL) ? FULL
                                     : fill_q + 1'b1;
  assign accept   = d_valid && !pat_load;
  // fill guards against matching on stale or cleared history
  assign match    = accept
                 && (fill_inc == FULL)
                 && (hist_sh == pat_q);

  always_comb begin
    pat_d  = pat_q;
    hist_d = hist_q;
    fill_d = fill_q;
    det_d  = det_q;
    cnt_d  = cnt_q;
    if (pat_load) begin
      pat_d  = pat_in;
      hist_d = '0;
      fill_d = '0;
      det_d  = 1'b0;
    end else if (d_valid) begin
      hist_d = hist_sh;
      // non-overlap: restart fill so no match bit is reused
      fill_d = (match && !OVERLAP) ? '0 : fill_inc;
      det_d  = match;
    end
    if (cnt_clr)
      cnt_d = '0;
    else if (match && cnt_q != CNT_MAX)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge slowed_clk) begin
    if (reset) begin
      pat_q  <= PATTERN;
      hist_q <= '0;
      fill_q <= '0;
      det_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      det_q  <= det_d;
      cnt_q  <= cnt_d;
    end
  end

  assign detected    = det_q;
  assign match_count = cnt_q;

endmodule

// File: tb/tb_param_seq_detector.sv
// tb_param_seq_detector: directed bench for param_seq_detector,
// three instances (overlap, non-overlap, 2-bit counter).
module tb_param_seq_detector;

  logic       slowed_clk = 1'b0;
  logic       reset = 1'b0;
  logic       d_in = 1'b0;
  logic       d_valid = 1'b0;
  logic [4:0] pat_in = '0;
  logic       pat_load = 1'b0;
  logic       cnt_clr = 1'b0;

  logic       det_ov, det_no, det_sat;
  logic [7:0] cnt_ov, cnt_no;
  logic [1:0] cnt_sat;

  int checks = 0;
  int failures = 0;

  always #5 slowed_clk = ~slowed_clk;

  param_seq_detector u_ov (
    .slowed_clk(slowed_clk), .reset(reset),
    .d_in(d_in), .d_valid(d_valid),
    .pat_in(pat_in), .pat_load(pat_load),
    .cnt_clr(cnt_clr),
    .detected(det_ov), .match_count(cnt_ov)
  );

  param_seq_detector #(.OVERLAP(1'b0)) u_no (
    .slowed_clk(slowed_clk), .reset(reset),
    .d_in(d_in), .d_valid(d_valid),
    .pat_in(pat_in), .pat_load(pat_load),
    .cnt_clr(cnt_clr),
    .detected(det_no), .match_count(cnt_no)
  );

  param_seq_detector #(.CNT_W(2)) u_sat (
    .slowed_clk(slowed_clk), .reset(reset),
    .d_in(d_in), .d_valid(d_valid),
    .pat_in(pat_in), .pat_load(pat_load),
    .cnt_clr(cnt_clr),
    .detected(det_sat), .match_count(cnt_sat)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge slowed_clk);
    #1;
  endtask

  task automatic bit_in(input logic b);
    d_valid = 1'b1;
    d_in = b;
    tick();
    d_valid = 1'b0;
    d_in = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  logic [8:0] s_ov;
  logic [8:0] e_ov;
  logic [8:0] e_no;
  logic [4:0] s5;

  initial begin
    tick();
    reset = 1'b1;
    d_valid = 1'b1;
    d_in = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    d_valid = 1'b0;
    d_in = 1'b0;
    chk("rst_det_ov", det_ov, 0);
    chk("rst_cnt_ov", cnt_ov, 0);
    chk("rst_cnt_sat", cnt_sat, 0);

    // overlap / non-overlap: 1,0,0,0,1,0,0,0,1
    s_ov = 9'b100010001;
    e_ov = 9'b000010001;
    e_no = 9'b000010000;
    for (int i = 0; i < 9; i++) begin
      bit_in(s_ov[8-i]);
      chk($sformatf("ov_det_b%0d", i + 1),
          det_ov, e_ov[8-i]);
      chk($sformatf("no_det_b%0d", i + 1),
          det_no, e_no[8-i]);
    end
    chk("ov_cnt", cnt_ov, 2);
    chk("no_cnt", cnt_no, 1);
    chk("sat_cnt_2", cnt_sat, 2);

    // valid gaps: 3 idle cycles between bits
    do_reset();
    s5 = 5'b10001;
    for (int i = 0; i < 5; i++) begin
      bit_in(s5[4-i]);
      for (int k = 0; k < 3; k++) begin
        tick();
        if (i == 4)
          chk($sformatf("gap_hold_%0d", k),
              det_ov, 1);
        else
          chk($sformatf("gap_lo_%0d_%0d", i, k),
              det_ov, 0);
      end
    end
    chk("gap_cnt", cnt_ov, 1);
    bit_in(1'b0);
    chk("gap_drop", det_ov, 0);

    // saturation on 2-bit counter: history ends ...100010
    bit_in(1'b0);
    bit_in(1'b0);
    bit_in(1'b1);
    chk("sat_m2_det", det_sat, 1);
    chk("sat_m2_cnt", cnt_sat, 2);
    for (int i = 0; i < 4; i++) bit_in(i == 3);
    chk("sat_m3_cnt", cnt_sat, 3);
    for (int i = 0; i < 4; i++) bit_in(i == 3);
    chk("sat_m4_det", det_sat, 1);
    chk("sat_m4_cnt", cnt_sat, 3);
    chk("ov_m4_cnt", cnt_ov, 4);

    // runtime pattern load, bit in load cycle ignored
    pat_in = 5'b11111;
    pat_load = 1'b1;
    d_valid = 1'b1;
    d_in = 1'b1;
    tick();
    pat_load = 1'b0;
    d_valid = 1'b0;
    chk("load_det", det_ov, 0);
    chk("load_cnt", cnt_ov, 4);
    for (int i = 0; i < 6; i++) begin
      bit_in(1'b1);
      chk($sformatf("pat1_det_b%0d", i + 1),
          det_ov, (i >= 4) ? 1 : 0);
    end
    chk("pat1_cnt", cnt_ov, 6);
    chk("pat1_sat", cnt_sat, 3);

    // mid-sequence reset discards history
    do_reset();
    bit_in(1'b1);
    bit_in(1'b0);
    bit_in(1'b0);
    bit_in(1'b0);
    do_reset();
    bit_in(1'b1);
    chk("mid_det", det_ov, 0);
    chk("mid_cnt", cnt_ov, 0);
    for (int i = 0; i < 5; i++) begin
      bit_in(s5[4-i]);
      chk($sformatf("fresh_det_b%0d", i + 1),
          det_ov, (i == 4) ? 1 : 0);
    end
    chk("fresh_cnt", cnt_ov, 1);
    chk("fresh_no_cnt", cnt_no, 1);

    // clear has priority over simultaneous match
    bit_in(1'b0);
    bit_in(1'b0);
    bit_in(1'b0);
    cnt_clr = 1'b1;
    bit_in(1'b1);
    cnt_clr = 1'b0;
    chk("clr_det", det_ov, 1);
    chk("clr_cnt", cnt_ov, 0);
    chk("clr_no_det", det_no, 0);
    chk("clr_no_cnt", cnt_no, 0);
    tick();
    chk("clr_hold", det_ov, 1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/param_seq_detector.md
PARAM_SEQ_DETECTOR -- requirements
Module: param_seq_detector

Interface
REQ-001 The block SHALL have parameter PAT_LEN, default 5: pattern length in bits, legal range 2..16.
REQ-002 The block SHALL have parameter PATTERN, default 5'b10001: reset-time pattern; MSB is the first bit expected.
REQ-003 The block SHALL have parameter OVERLAP, default 1: 1 = overlapping matches counted, 0 = non-overlapping.
REQ-004 The block SHALL have parameter CNT_W, default 8: width of match_count.
REQ-005 The block SHALL have port slowed_clk, input, 1 bit: the block clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port d_in, input, 1 bit: serial data bit.
REQ-008 The block SHALL have port d_valid, input, 1 bit: d_in is accepted only on an edge where d_valid=1.
REQ-009 The block SHALL have port pat_in, input, PAT_LEN bits: runtime pattern value.
REQ-010 The block SHALL have port pat_load, input, 1 bit: loads pat_in into the active pattern register.
REQ-011 The block SHALL have port cnt_clr, input, 1 bit: synchronously clears match_count.
REQ-012 The block SHALL have port detected, output, 1 bit: registered Moore match flag.
REQ-013 The block SHALL have port match_count, output, CNT_W bits: saturating count of matches.

Function
REQ-014 The block SHALL keep a history register of the last PAT_LEN accepted bits, with the newest in the LSB, plus a fill counter of 0..PAT_LEN.
REQ-015 On each accepted bit, the block SHALL shift the bit into the history and increment fill, saturating at PAT_LEN.
REQ-016 A match SHALL occur on an accepted bit iff, after that shift, fill==PAT_LEN and history equals the active pattern.
REQ-017 On a match with OVERLAP=1, fill SHALL remain PAT_LEN.
REQ-018 On a match with OVERLAP=0, fill SHALL reset to 0 so that no match bit is reused.
REQ-019 detected SHALL be 1 in the cycle after the edge that accepted a matching bit (latency 1).
REQ-020 detected SHALL hold its value while d_valid=0.
REQ-021 detected SHALL be 0 after any accepted non-matching bit.
REQ-022 match_count SHALL increment by 1 per match and saturate at 2^CNT_W-1; it SHALL never wrap.
REQ-023 cnt_clr SHALL set match_count to 0 on the next edge, and SHALL take priority over a simultaneous match (count=0); detected is unaffected by cnt_clr.
REQ-024 pat_load=1 SHALL load pat_in, clear history and fill, and set detected=0.
REQ-025 While pat_load=1, any d_valid in the same cycle SHALL be ignored.
REQ-026 pat_load SHALL leave match_count unchanged.
REQ-027 The active pattern SHALL change only on reset (to PATTERN) or pat_load.
REQ-028 The fill counter SHALL prevent any match before PAT_LEN bits have been accepted since reset, pat_load, or a non-overlap match.
REQ-029 Precedence SHALL be reset > pat_load > d_valid; cnt_clr is independent of pat_load and d_valid.

Reset
REQ-030 On reset=1 at a slowed_clk edge, the block SHALL set: active pattern=PATTERN, history=0, fill=0, detected=0, match_count=0.
REQ-031 Reset SHALL override all other inputs in the same cycle.
REQ-032 Reset applied mid-sequence SHALL discard the partial history, so no match may complete using pre-reset bits.

Verification
REQ-033 Overlap case. Defaults, d_valid=1 continuous, stream 1,0,0,0,1,0,0,0,1 -> detected=1 one cycle after bit 5 and after bit 9, 0 otherwise; match_count=2.
REQ-034 Non-overlap case. OVERLAP=0, same stream -> detected only after bit 5; match_count=1.
REQ-035 Valid gaps and saturation. Stream 1,0,0,0,1 with d_valid=0 for 3 cycles between each bit -> single detection; detected holds high until the next accepted bit. Then with CNT_W=2 and 4 matches -> match_count=3, with no wrap.
REQ-036 Runtime pattern. pat_load with pat_in=5'b11111 while history is partly filled, then six accepted 1s -> matches on bits 5 and 6, match_count incremented by 2. Bits accepted in the load cycle are ignored.
REQ-037 Mid-sequence reset. Stream 1,0,0,0, then reset, then 1 -> no detection, match_count=0. A fresh 1,0,0,0,1 afterwards -> one detection.
REQ-038 Clear priority. cnt_clr asserted on the same edge as a match -> match_count=0 and detected=1.
